// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional bounds checking is enabled with FETCH_BOUNDS_CHECK_EN.
package fetch_pkg;
    localparam int ILEN = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instruction, PC} pairs toward decode.
// Flush wins over push/pop; head outputs read as zero when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [ILEN-1:0]         push_instr,
    input  logic [31:0]             push_pc,
    input  logic                    pop,
    output logic                    head_valid,
    output logic [ILEN-1:0]         head_instr,
    output logic [31:0]             head_pc,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    // A full queue still accepts a push when the head leaves this cycle.
    assign do_push    = push && ((count != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, one in-flight request,
// fetch queue toward decode. FETCH_BOUNDS_CHECK_EN adds the FAULT state.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_BYTES = 1024,
    parameter int          FQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
`ifdef FETCH_BOUNDS_CHECK_EN
    output logic        fault,
`endif
    output logic        halted
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0
        || IMEM_BYTES < 4) begin : g_bad_cfg
        $error("fetch_controller: illegal parameter set");
    end

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [31:0]   inflight_pc;
    logic          inflight_q;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          credit;
    logic          resp_push;
    logic          resp_stop;
    logic          oob;
    logic          issue;

    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign credit    = occ < (CW+1)'(FQ_DEPTH);
    assign resp_push = inflight_q && !imem_stop && !redirect_valid;
    assign resp_stop = inflight_q && imem_stop && !redirect_valid;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);
    assign oob   = pc_q > PC_MAX;
    assign fault = (state_q == FAULT);
`else
    assign oob   = 1'b0;
`endif

    // No new request in the cycle the stop word returns.
    assign issue = (state_q == FETCH) && !redirect_valid
                && !resp_stop && !oob && credit;

    assign imem_pc = pc_q;
    assign halted  = (state_q != FETCH);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (1'b1)
            redirect_valid: begin
                state_d = FETCH;
                pc_d    = redirect_pc;
            end
            resp_stop: begin
                state_d = HALT;
                pc_d    = inflight_pc;
            end
            default: begin
                if (issue) begin
                    pc_d = pc_q + PC_INC;
                end else if (state_q == FETCH && oob) begin
                    state_d = FAULT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc <= pc_q;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (resp_push),
        .push_instr (imem_instr),
        .push_pc    (inflight_pc),
        .pop        (fetch_ready),
        .head_valid (fetch_valid),
        .head_instr (fetch_instr),
        .head_pc    (fetch_pc),
        .count      (count)
    );
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a registered memory model
// and a PC scoreboard checked at every decode handshake.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        imem_stop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        halted;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic        fault;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:255];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    fetch_controller #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (1024),
        .FQ_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .imem_stop      (imem_stop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
`ifdef FETCH_BOUNDS_CHECK_EN
        .fault          (fault),
`endif
        .halted         (halted)
    );

    always @(posedge clk) begin
        imem_instr <= mem[imem_pc[9:2]];
        imem_stop  <= (mem[imem_pc[9:2]] == 32'h0);
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hC000_0000 | {pc[31:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && fetch_valid && fetch_ready && !redirect_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: observed pc %h expected none", fetch_pc);
            end
            if (sb.size() != 0) begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("deliv_pc", fetch_pc, e);
                chk("deliv_instr", fetch_instr, word_of(e));
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word_of(32'(i) << 2);
        rst_n          = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #12;
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", fetch_instr, 32'h0);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Program 0,4,8 then a zero word at 12.
        mem[3] = 32'h0;
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        fetch_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        wait_halt("s1_halt");
        chk("s1_stop_pc", imem_pc, 32'hC);
        tick(6);
        chk("s1_drained", 32'(sb.size()), 32'd0);
        chk("s1_valid", 32'(fetch_valid), 32'd0);

        // Stall decode: exactly four entries, head held.
        mem[3] = word_of(32'hC);
        mem[4] = 32'h0;
        fetch_ready = 1'b0;
        @(posedge clk); #1;
        redirect(32'h0);
        chk("s2_unhalt", 32'(halted), 32'd0);
        chk("s2_lat1", 32'(fetch_valid), 32'd0);
        tick(1);
        chk("s2_lat2", 32'(fetch_valid), 32'd0);
        tick(1);
        chk("s2_lat3", 32'(fetch_valid), 32'd1);
        tick(8);
        chk("s2_full_pc", fetch_pc, 32'h0);
        chk("s2_full_instr", fetch_instr, word_of(32'h0));
        chk("s2_no_issue", imem_pc, 32'h10);
        for (int p = 0; p < 16; p += 4) sb.push_back(32'(p));
        fetch_ready = 1'b1;
        wait_halt("s2_halt");
        tick(6);
        chk("s2_drained", 32'(sb.size()), 32'd0);
        chk("s2_stop_pc", imem_pc, 32'h10);

        // Redirect with two queued and one in flight.
        mem[4]  = word_of(32'h10);
        mem[19] = 32'h0;
        fetch_ready = 1'b0;
        redirect(32'h0);
        tick(3);
        chk("s3_head", fetch_pc, 32'h0);
        redirect(32'h40);
        chk("s3_flushed", 32'(fetch_valid), 32'd0);
        chk("s3_new_pc", imem_pc, 32'h40);
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        sb.push_back(32'h48);
        fetch_ready = 1'b1;
        wait_halt("s3_halt");
        tick(6);
        chk("s3_drained", 32'(sb.size()), 32'd0);
        mem[19] = word_of(32'h4C);

`ifdef FETCH_BOUNDS_CHECK_EN
        sb.push_back(32'd1020);
        redirect(32'd1020);
        begin
            int n = 0;
            while (fault !== 1'b1 && n < 20) begin
                tick(1);
                n++;
            end
        end
        chk("s4_fault", 32'(fault), 32'd1);
        chk("s4_halted", 32'(halted), 32'd1);
        chk("s4_no_issue", imem_pc, 32'd1024);
        tick(4);
        chk("s4_drained", 32'(sb.size()), 32'd0);
`endif

        // Unaligned redirect, fill, then reset mid-stream.
        fetch_ready = 1'b0;
        redirect(32'h51);
        chk("s5_unaligned", imem_pc, 32'h51);
        chk("s5_unhalt", 32'(halted), 32'd0);
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("s5_unfault", 32'(fault), 32'd0);
`endif
        tick(8);
        chk("s5_full", 32'(fetch_valid), 32'd1);
        chk("s5_head", fetch_pc, 32'h51);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(fetch_valid), 32'd0);
        chk("s5_rst_pc", imem_pc, 32'h0);
        mem[4] = 32'h0;
        for (int p = 0; p < 16; p += 4) sb.push_back(32'(p));
        fetch_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        wait_halt("s5_halt");
        tick(6);
        chk("s5_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
